// File: rtl/pmodnav_axi_poller_if.sv
// pmodnav_axi_poller_if
//   AXI4-Lite read channels (AR + R) between the poller and the PmodNAV
//   register slave. Write channels are absent: the poller never writes.
//   master : driven by the poller (ARADDR/ARPROT/ARVALID/RREADY out)
//   slave  : driven by the register block (ARREADY/RDATA/RRESP/RVALID out)
interface pmodnav_axi_poller_if #(
    parameter int C_M_AXI_ADDR_WIDTH = 7,
    parameter int C_M_AXI_DATA_WIDTH = 32
);
    logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR;
    logic [2:0]                    M_AXI_ARPROT;
    logic                          M_AXI_ARVALID;
    logic                          M_AXI_ARREADY;
    logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA;
    logic [1:0]                    M_AXI_RRESP;
    logic                          M_AXI_RVALID;
    logic                          M_AXI_RREADY;

    modport master (
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, M_AXI_RREADY,
        input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
    );

    modport slave (
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, M_AXI_RREADY,
        output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
    );
endinterface

// File: rtl/pmodnav_axi_poller.sv
// pmodnav_axi_poller
//   AXI4-Lite read-only master. Every C_POLL_DIV cycles (when enabled) it
//   sweeps C_NUM_REGS consecutive 32-bit registers starting at C_BASE_ADDR
//   and re-emits each word as a valid/ready sample.
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   enable          poll ticks start sweeps while high
//   m_axi           AXI4-Lite AR/R master channels
//   smp_*           sample stream (data, index in sweep, last, RRESP error)
//   busy            FSM not idle
//   overrun         sticky: tick dropped because a sweep was still running
//   stall_err       sticky: AR or R wait reached C_TIMEOUT cycles
//   resp_err        sticky: any non-OKAY read response
module pmodnav_axi_poller #(
    parameter int                          C_M_AXI_ADDR_WIDTH = 7,
    parameter int                          C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR      = 7'h20,
    parameter int                          C_NUM_REGS         = 7,
    parameter int                          C_POLL_DIV         = 100000,
    parameter int                          C_TIMEOUT          = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    pmodnav_axi_poller_if.master          m_axi,
    output logic                          smp_valid,
    input  logic                          smp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] smp_data,
    output logic [2:0]                    smp_idx,
    output logic                          smp_last,
    output logic                          smp_err,
    output logic                          busy,
    output logic                          overrun,
    output logic                          stall_err,
    output logic                          resp_err
);
    localparam int AW     = C_M_AXI_ADDR_WIDTH;
    localparam int DW     = C_M_AXI_DATA_WIDTH;
    localparam int CNT_W  = (C_POLL_DIV > 1) ? $clog2(C_POLL_DIV) : 1;
    localparam int WAIT_W = $clog2(C_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_OUT} state_t;

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [AW-1:0]     araddr_q, araddr_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              smp_valid_q, smp_valid_d;
    logic [DW-1:0]     smp_data_q, smp_data_d;
    logic [2:0]        smp_idx_q, smp_idx_d;
    logic              smp_last_q, smp_last_d;
    logic              smp_err_q, smp_err_d;
    logic              overrun_q, overrun_d;
    logic              stall_q, stall_d;
    logic              resp_q, resp_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  tick_cnt_q;
    logic              tick;
    logic              ar_hs, r_hs, is_last;

    // Register address for a sweep index; wraps modulo 2^AW.
    function automatic logic [AW-1:0] reg_addr(input logic [2:0] i);
        return C_BASE_ADDR + (AW'(i) << 2);
    endfunction

    // Free-running poll divider, independent of enable so the tick phase
    // does not drift when polling is toggled.
    assign tick = (tick_cnt_q == CNT_W'(C_POLL_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       tick_cnt_q <= '0;
        else if (tick) tick_cnt_q <= '0;
        else           tick_cnt_q <= tick_cnt_q + 1'b1;
    end

    assign ar_hs   = arvalid_q & m_axi.M_AXI_ARREADY;
    assign r_hs    = rready_q & m_axi.M_AXI_RVALID;
    assign is_last = (idx_q == 3'(C_NUM_REGS - 1));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        smp_valid_d = smp_valid_q;
        smp_data_d  = smp_data_q;
        smp_idx_d   = smp_idx_q;
        smp_last_d  = smp_last_q;
        smp_err_d   = smp_err_q;
        overrun_d   = overrun_q;
        stall_d     = stall_q;
        resp_d      = resp_q;
        wait_d      = wait_q;

        // A tick landing mid-sweep is dropped, not queued.
        if (tick && (state_q != S_IDLE)) overrun_d = 1'b1;

        // Shared AR/R wait accounting: saturating count, flag on reaching
        // the limit. The transaction keeps waiting; AXI has no abort.
        if ((state_q == S_AR && !ar_hs) || (state_q == S_R && !r_hs)) begin
            if (wait_q != WAIT_W'(C_TIMEOUT)) wait_d = wait_q + 1'b1;
            if (wait_q == WAIT_W'(C_TIMEOUT - 1)) stall_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (tick && enable) begin
                    state_d   = S_AR;
                    idx_d     = '0;
                    araddr_d  = reg_addr(3'd0);
                    arvalid_d = 1'b1;
                    wait_d    = '0;
                end
            end
            S_AR: begin
                if (ar_hs) begin
                    state_d   = S_R;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    wait_d    = '0;
                end
            end
            S_R: begin
                if (r_hs) begin
                    state_d     = S_OUT;
                    rready_d    = 1'b0;
                    smp_valid_d = 1'b1;
                    smp_data_d  = m_axi.M_AXI_RDATA;
                    smp_err_d   = (m_axi.M_AXI_RRESP != 2'b00);
                    resp_d      = resp_q | (m_axi.M_AXI_RRESP != 2'b00);
                    smp_idx_d   = idx_q;
                    smp_last_d  = is_last;
                end
            end
            S_OUT: begin
                if (smp_ready) begin
                    smp_valid_d = 1'b0;
                    if (is_last) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_AR;
                        idx_d     = idx_q + 1'b1;
                        araddr_d  = reg_addr(idx_q + 1'b1);
                        arvalid_d = 1'b1;
                        wait_d    = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            smp_valid_q <= 1'b0;
            smp_data_q  <= '0;
            smp_idx_q   <= '0;
            smp_last_q  <= 1'b0;
            smp_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
            stall_q     <= 1'b0;
            resp_q      <= 1'b0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            smp_valid_q <= smp_valid_d;
            smp_data_q  <= smp_data_d;
            smp_idx_q   <= smp_idx_d;
            smp_last_q  <= smp_last_d;
            smp_err_q   <= smp_err_d;
            overrun_q   <= overrun_d;
            stall_q     <= stall_d;
            resp_q      <= resp_d;
            wait_q      <= wait_d;
        end
    end

    assign m_axi.M_AXI_ARADDR  = araddr_q;
    assign m_axi.M_AXI_ARPROT  = 3'b000;
    assign m_axi.M_AXI_ARVALID = arvalid_q;
    assign m_axi.M_AXI_RREADY  = rready_q;

    assign smp_valid = smp_valid_q;
    assign smp_data  = smp_data_q;
    assign smp_idx   = smp_idx_q;
    assign smp_last  = smp_last_q;
    assign smp_err   = smp_err_q;
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;
    assign stall_err = stall_q;
    assign resp_err  = resp_q;
endmodule
